// File: rtl/simplez_loader_if.sv
// Signal bundle between the Simplez serial loader and its UART pair, genram
// write port and CPU reset line.
interface simplez_loader_if #(
   parameter int AW = 4,
   parameter int DW = 12
);
   logic [7:0]    rx_data;
   logic          rx_rcv;
   logic          tx_ready;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic          cpu_rstn;
   logic          busy;
   logic          error;

   modport slave (
      input  rx_data, rx_rcv, tx_ready,
      output tx_data, tx_start, mem_addr, mem_din, mem_we, cpu_rstn, busy, error
   );

   modport master (
      output rx_data, rx_rcv, tx_ready,
      input  tx_data, tx_start, mem_addr, mem_din, mem_we, cpu_rstn, busy, error
   );
endinterface

// File: rtl/simplez_loader.sv
// Serial program loader for the Simplez core: framed bytes in, genram words out.
// Optional inter-byte timeout is enabled with `define SIMPLEZ_LOADER_TIMEOUT_EN.
module simplez_loader #(
   parameter int         AW      = 4,
   parameter int         DW      = 12,
   parameter logic [7:0] HEADER  = 8'h4C,
   parameter logic [7:0] ACK_OK  = 8'h4B,
   parameter logic [7:0] ACK_ERR = 8'h45
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
  ,parameter int         TIMEOUT = 2400000
`endif
) (
   input logic             clk,
   input logic             rstn,
   simplez_loader_if.slave bus
);

   localparam int LP_MAXN = 2 ** AW;

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHK, S_ACK
   } state_t;

   state_t        r_state, w_state;
   logic [7:0]    r_tx_data, w_tx_data;
   logic          r_tx_start, w_tx_start;
   logic [AW-1:0] r_mem_addr, w_mem_addr;
   logic [DW-1:0] r_mem_din, w_mem_din;
   logic          r_mem_we, w_mem_we;
   logic          r_cpu_rstn, w_cpu_rstn;
   logic          r_busy, w_busy;
   logic          r_error, w_error;
   logic [7:0]    r_sum, w_sum;
   logic [3:0]    r_hi, w_hi;
   logic [8:0]    r_remain, w_remain;
   logic          r_ok, w_ok;

`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
   localparam int            LP_TW      = $clog2(TIMEOUT + 1);
   localparam logic [LP_TW-1:0] LP_TMO_MAX = LP_TW'(TIMEOUT - 1);
   logic [LP_TW-1:0] r_timer, w_timer;
   logic             w_timeout;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_mem_we   <= 1'b0;
         r_cpu_rstn <= 1'b1;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
         r_sum      <= '0;
         r_hi       <= '0;
         r_remain   <= '0;
         r_ok       <= 1'b0;
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
         r_timer    <= '0;
`endif
      end else begin
         r_state    <= w_state;
         r_tx_data  <= w_tx_data;
         r_tx_start <= w_tx_start;
         r_mem_addr <= w_mem_addr;
         r_mem_din  <= w_mem_din;
         r_mem_we   <= w_mem_we;
         r_cpu_rstn <= w_cpu_rstn;
         r_busy     <= w_busy;
         r_error    <= w_error;
         r_sum      <= w_sum;
         r_hi       <= w_hi;
         r_remain   <= w_remain;
         r_ok       <= w_ok;
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
         r_timer    <= w_timer;
`endif
      end
   end

   always_comb begin
      w_state    = r_state;
      w_tx_data  = r_tx_data;
      w_tx_start = 1'b0;
      w_mem_addr = r_mem_addr;
      w_mem_din  = r_mem_din;
      w_mem_we   = 1'b0;
      w_cpu_rstn = r_cpu_rstn;
      w_busy     = r_busy;
      w_error    = r_error;
      w_sum      = r_sum;
      w_hi       = r_hi;
      w_remain   = r_remain;
      w_ok       = r_ok;
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
      w_timer    = '0;
      w_timeout  = 1'b0;
      if (r_state inside {S_COUNT, S_HI, S_LO, S_CHK}) begin
         if (bus.rx_rcv)
            w_timer = '0;
         else if (r_timer == LP_TMO_MAX)
            w_timeout = 1'b1;
         else
            w_timer = r_timer + 1'b1;
      end
`endif

      case (r_state)
         S_IDLE: begin
            if (bus.rx_rcv && bus.rx_data == HEADER) begin
               w_state    = S_COUNT;
               w_cpu_rstn = 1'b0;
               w_busy     = 1'b1;
               w_error    = 1'b0;
               w_sum      = '0;
               w_mem_addr = '0;
               w_ok       = 1'b0;
            end
         end
         S_COUNT: begin
            if (bus.rx_rcv) begin
               if (bus.rx_data == 8'd0 || int'(bus.rx_data) > LP_MAXN) begin
                  w_error   = 1'b1;
                  w_tx_data = ACK_ERR;
                  w_state   = S_ACK;
               end else begin
                  w_remain = {1'b0, bus.rx_data};
                  w_state  = S_HI;
               end
            end
         end
         S_HI: begin
            if (bus.rx_rcv) begin
               w_hi    = bus.rx_data[3:0];
               w_sum   = r_sum + bus.rx_data;
               w_state = S_LO;
            end
         end
         S_LO: begin
            if (bus.rx_rcv) begin
               w_sum     = r_sum + bus.rx_data;
               w_mem_din = {r_hi, bus.rx_data};
               w_mem_we  = 1'b1;
               w_state   = S_WRITE;
            end
         end
         S_WRITE: begin
            // The last word leaves the address in place so it can never wrap.
            if (r_remain == 9'd1) begin
               w_state = S_CHK;
            end else begin
               w_mem_addr = r_mem_addr + 1'b1;
               w_state    = S_HI;
            end
            w_remain = r_remain - 9'd1;
         end
         S_CHK: begin
            if (bus.rx_rcv) begin
               if (bus.rx_data == r_sum) begin
                  w_tx_data = ACK_OK;
                  w_ok      = 1'b1;
               end else begin
                  w_tx_data = ACK_ERR;
                  w_error   = 1'b1;
               end
               w_state = S_ACK;
            end
         end
         S_ACK: begin
            // CPU reset is released together with the acknowledge pulse.
            if (bus.tx_ready) begin
               w_tx_start = 1'b1;
               w_busy     = 1'b0;
               if (r_ok)
                  w_cpu_rstn = 1'b1;
               w_state = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase

`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
      if (w_timeout) begin
         w_error   = 1'b1;
         w_tx_data = ACK_ERR;
         w_ok      = 1'b0;
         w_mem_we  = 1'b0;
         w_state   = S_ACK;
      end
`endif
   end

   assign bus.tx_data  = r_tx_data;
   assign bus.tx_start = r_tx_start;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_din  = r_mem_din;
   assign bus.mem_we   = r_mem_we;
   assign bus.cpu_rstn = r_cpu_rstn;
   assign bus.busy     = r_busy;
   assign bus.error    = r_error;

endmodule

// File: tb/tb_simplez_loader.sv
// Randomised scoreboard bench for simplez_loader: a frame-level model queues
// the expected RAM writes and acknowledges, a negedge monitor consumes them.
module tb_simplez_loader;
   localparam int         AW  = 4;
   localparam int         DW  = 12;
   localparam logic [7:0] HDR = 8'h4C;
   localparam logic [7:0] OK  = 8'h4B;
   localparam logic [7:0] ERR = 8'h45;

   typedef logic [7:0] bq_t[$];
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct { logic [7:0] b; logic ok; } ack_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   simplez_loader_if #(.AW(AW), .DW(DW)) bus ();

   simplez_loader #(
      .AW(AW), .DW(DW), .HEADER(HDR), .ACK_OK(OK), .ACK_ERR(ERR)
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
     ,.TIMEOUT(50)
`endif
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   wr_t  wq[$];
   ack_t aq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Frame-level reference: what a correct loader must write and reply.
   task automatic model_frame(input bq_t f);
      int         n;
      logic [7:0] s;
      ack_t       a;
      wr_t        w;
      n = int'(f[1]);
      if (n == 0 || n > 2 ** AW) begin
         a.b = ERR; a.ok = 1'b0; aq.push_back(a);
         return;
      end
      s = 8'd0;
      for (int i = 0; i < n; i++) begin
         w.a = AW'(i);
         w.d = {f[2+2*i][3:0], f[3+2*i]};
         wq.push_back(w);
         s = s + f[2+2*i] + f[3+2*i];
      end
      a.ok = (f[2+2*n] == s);
      a.b  = a.ok ? OK : ERR;
      aq.push_back(a);
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data = b;
      bus.rx_rcv  = 1'b1;
      @(posedge clk); #1;
      bus.rx_rcv  = 1'b0;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
   endtask

   task automatic send_bytes(input bq_t f);
      foreach (f[i]) begin
         send(f[i]);
         if (i == 0) begin
            check("busy_after_header", bus.busy, 1);
            check("cpu_held_after_header", bus.cpu_rstn, 0);
         end
      end
   endtask

   task automatic wait_ack();
      int t = 0;
      while (aq.size() != 0 && t < 5000) begin
         @(posedge clk); t++;
      end
      if (aq.size() != 0) begin
         flag("ack_timeout");
         aq.delete(); wq.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bq_t f);
      model_frame(f);
      send_bytes(f);
      wait_ack();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_tx_data"},  bus.tx_data, 0);
      check({tag, "_tx_start"}, bus.tx_start, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_din"},  bus.mem_din, 0);
      check({tag, "_mem_we"},   bus.mem_we, 0);
      check({tag, "_cpu_rstn"}, bus.cpu_rstn, 1);
      check({tag, "_busy"},     bus.busy, 0);
      check({tag, "_error"},    bus.error, 0);
   endtask

   // Monitor: consumes expected writes/acks whenever the DUT presents them.
   logic prev_we, prev_start;
   wr_t  mw;
   ack_t ma;
   always @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_we    <= 1'b0;
         prev_start <= 1'b0;
      end else begin
         if (bus.mem_we) begin
            if (prev_we) flag("mem_we_longer_than_one_cycle");
            if (wq.size() == 0) flag("unexpected_write");
            else begin
               mw = wq.pop_front();
               check("wr_addr", bus.mem_addr, mw.a);
               check("wr_data", bus.mem_din, mw.d);
               check("cpu_held_during_write", bus.cpu_rstn, 0);
            end
         end
         if (bus.tx_start) begin
            if (prev_start) flag("tx_start_longer_than_one_cycle");
            if (aq.size() == 0) flag("unexpected_ack");
            else begin
               ma = aq.pop_front();
               check("ack_byte", bus.tx_data, ma.b);
               check("ack_error", bus.error, !ma.ok);
               check("ack_cpu_rstn", bus.cpu_rstn, ma.ok);
               check("ack_busy", bus.busy, 0);
               check("ack_tx_ready", bus.tx_ready, 1);
               check("writes_done_at_ack", wq.size(), 0);
               wq.delete();
            end
         end
         prev_we    <= bus.mem_we;
         prev_start <= bus.tx_start;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t f;
      int  n;
      logic [7:0] s;

      bus.rx_data  = 8'h00;
      bus.rx_rcv   = 1'b0;
      bus.tx_ready = 1'b1;
      #17;
      check_reset_vals("reset");
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(posedge clk); #1;

      send_frame('{8'h4C, 8'h02, 8'h05, 8'hF3, 8'h0E, 8'h00, 8'h06});
      check("good_frame_error", bus.error, 0);
      check("good_frame_cpu_run", bus.cpu_rstn, 1);

      send_frame('{8'h4C, 8'h01, 8'h07, 8'h00, 8'h00});
      check("bad_chk_error_sticky", bus.error, 1);
      check("bad_chk_cpu_held", bus.cpu_rstn, 0);
      send_frame('{8'h4C, 8'h01, 8'h07, 8'h00, 8'h07});
      check("recover_error", bus.error, 0);
      check("recover_cpu_run", bus.cpu_rstn, 1);

      send_frame('{8'h4C, 8'h00});
      check("count0_error", bus.error, 1);
      send_frame('{8'h4C, 8'h11});
      check("count17_error", bus.error, 1);

      send(8'h12); send(8'h34);
      check("junk_idle_busy", bus.busy, 0);
      f = '{8'h4C, 8'h10};
      s = 8'd0;
      for (int i = 0; i < 32; i++) begin
         f.push_back(8'($urandom));
         s = s + f[$];
      end
      f.push_back(s);
      send_frame(f);

      // Acknowledge held off by a busy transmitter; stray bytes must be dropped.
      bus.tx_ready = 1'b0;
      f = '{8'h4C, 8'h01, 8'hA1, 8'h23, 8'h44};
      model_frame(f);
      send_bytes(f);
      send(8'h4C); send(8'h01);
      repeat (100) @(posedge clk); #1;
      check("ack_held_while_tx_busy", aq.size(), 1);
      bus.tx_ready = 1'b1;
      wait_ack();
      check("header_in_ack_ignored", bus.busy, 0);

      for (int k = 0; k < 20; k++) begin
         n = $urandom_range(1, 16);
         f = '{8'h4C, 8'(n)};
         s = 8'd0;
         for (int i = 0; i < 2 * n; i++) begin
            f.push_back(8'($urandom));
            s = s + f[$];
         end
         if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
         f.push_back(s);
         send_frame(f);
      end

`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
      begin
         ack_t a;
         a.b = ERR; a.ok = 1'b0;
         aq.push_back(a);
         send_bytes('{8'h4C, 8'h02, 8'h05});
         wait_ack();
         check("timeout_idle_busy", bus.busy, 0);
         check("timeout_error", bus.error, 1);
      end
`endif

      send_bytes('{8'h4C, 8'h02, 8'h05});
      rstn = 1'b0;
      #1;
      check_reset_vals("midframe_reset");
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(posedge clk); #1;
      send_frame('{8'h4C, 8'h01, 8'h3C, 8'h5A, 8'h96});
      check("post_reset_cpu_run", bus.cpu_rstn, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
